// File: rtl/i_fetch.sv
// i_fetch -- LEGv8 instruction-fetch stage.
//
// Holds the program counter, issues byte addresses to a synchronous
// instruction memory (one-cycle read latency), and buffers returned words
// in a 2-entry {pc, instr} queue. Decode takes them over a valid/ready
// handshake. A redirect from the memory stage (i_pc_src) flushes the queue,
// drops the response in flight, and issues the branch target in the same cycle.
//
// Ports
//   i_clk            clock, rising edge
//   i_reset          synchronous active-high reset
//   i_pc_src         redirect request
//   i_branch_target  redirect byte address (used only when i_pc_src = 1)
//   o_imem_req       instruction-memory read enable
//   o_imem_addr      instruction-memory byte address
//   i_imem_rdata     instruction word, valid the cycle after o_imem_req
//   o_out_valid      instruction presented to decode
//   i_out_ready      decode accepts this cycle
//   o_out_pc         PC of the presented instruction
//   o_out_instr      presented instruction
module i_fetch #(
  parameter int              WORD     = 64,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pc_src,
  input  logic [WORD-1:0] i_branch_target,
  output logic            o_imem_req,
  output logic [WORD-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [WORD-1:0] o_out_pc,
  output logic [31:0]     o_out_instr
);

  logic [WORD-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [WORD-1:0] r_inflight_pc;
  logic [1:0]      r_count;
  logic            r_head;
  logic [WORD-1:0] r_fifo_pc    [0:1];
  logic [31:0]     r_fifo_instr [0:1];

  logic            w_pop;
  logic            w_push;
  logic            w_tail;
  logic [2:0]      w_occupancy;
  logic [1:0]      w_count_next;

  // Gating with reset keeps the presented valid low while state is being cleared.
  assign o_out_valid = (r_count != 2'd0) & ~i_pc_src & ~i_reset;
  assign o_out_pc    = r_fifo_pc[r_head];
  assign o_out_instr = r_fifo_instr[r_head];

  assign w_pop  = o_out_valid & i_out_ready;
  assign w_push = r_inflight & ~i_pc_src;

  // Queue entries plus the outstanding response after this cycle's pop.
  // Capping this at 2 guarantees every response has a slot waiting for it.
  assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

  assign o_imem_addr = i_pc_src ? i_branch_target : r_fetch_pc;
  assign o_imem_req  = ~i_reset & (i_pc_src | (w_occupancy < 3'd2));

  // A push never sees a full queue, so the tail is head + count (mod 2).
  // When count = 1 and a pop happens too, the new entry becomes the head.
  assign w_tail       = r_head ^ r_count[0];
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
    end else begin
      if (o_imem_req) begin
        // Wraps modulo 2^WORD at the top of the address space.
        r_fetch_pc    <= o_imem_addr + {{(WORD-3){1'b0}}, 3'd4};
        r_inflight    <= 1'b1;
        r_inflight_pc <= o_imem_addr;
      end else begin
        r_inflight    <= 1'b0;
      end

      if (w_push) begin
        r_fifo_pc[w_tail]    <= r_inflight_pc;
        r_fifo_instr[w_tail] <= i_imem_rdata;
      end

      if (w_pop) begin
        r_head <= ~r_head;
      end

      r_count <= i_pc_src ? 2'd0 : w_count_next;
    end
  end

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction-fetch stage for the LEGv8 datapath. It holds the program counter, issues byte addresses to a synchronous instruction memory, and buffers returned instructions in a 2-entry queue. It presents each instruction with its PC to decode over a valid/ready handshake. It consumes `pc_src` and the branch target produced by the memory stage to redirect fetch and flush wrong-path instructions.

## Interface
- `WORD`, `` `WORD `` from definitions.vh (64): PC and address width.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_src`  in  1  redirect request from the memory stage (uncondbranch | branch&zero).
- `branch_target`  in  WORD  redirect byte address; sampled only when `pc_src`=1.
- `imem_req`  out  1  read enable to instruction memory.
- `imem_addr`  out  WORD  byte address to instruction memory.
- `imem_rdata`  in  32  instruction word, valid the cycle after the matching `imem_req`.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts this cycle.
- `out_pc`  out  WORD  PC of presented instruction.
- `out_instr`  out  32  presented instruction.

## Operation
- State:
  - `fetch_pc` (WORD): next sequential address.
  - `inflight` (1b) and `inflight_pc` (WORD): request issued last cycle.
  - 2-entry FIFO of {pc, instr} with `count` 0..2.
- `out_valid = (count != 0) & ~pc_src`; `out_pc`/`out_instr` come from the FIFO head; `pop = out_valid & out_ready`.
- `push = inflight & ~pc_src`: `imem_rdata` is written with `inflight_pc` at the FIFO tail.
- Issue address: `imem_addr = pc_src ? branch_target : fetch_pc`.
- Issue condition, sequential: `imem_req = ~reset & (count - pop + inflight < 2)`.
- Issue condition, on redirect: `imem_req = ~reset`. The FIFO is flushed and the in-flight response is dropped, so space is guaranteed.
- On issue: `fetch_pc <= imem_addr + 4`, modulo 2^WORD (wraps at the all-ones boundary with no error). Also `inflight <= 1` and `inflight_pc <= imem_addr`.
- No issue: `fetch_pc` holds and `inflight <= 0`.
- Redirect (`pc_src`=1):
  - FIFO count is cleared to 0.
  - The response arriving this cycle is discarded (no push).
  - `out_valid` is forced to 0, so no pop occurs.
  - `branch_target` is issued in the same cycle.
- Full FIFO with `out_ready`=0: no issue and no push; the outstanding response always has a reserved slot by construction of the issue rule. `imem_addr` holds `fetch_pc`.
- Simultaneous push and pop: count is unchanged, and the head advances while the new entry is written.
- A misaligned `branch_target` (low 2 bits nonzero) is passed through unmodified; alignment is the producer's responsibility.

## Timing
- Reset values: `out_valid`=0, `imem_req`=0 during reset, `fetch_pc`=RESET_PC, `count`=0, `inflight`=0; `out_pc`/`out_instr` are don't-care while `out_valid`=0.
- Reset asserted mid-operation clears all state at the next edge. Any outstanding response is ignored.
- First cycle after reset (C0): `imem_req`=1 with `imem_addr`=RESET_PC. The response arrives in C1 and is pushed, so `out_valid`=1 in C2 with `out_pc`=RESET_PC.
- Latency: 2 cycles from issue to `out_valid`.
- Throughput: with `out_ready` held high, the block sustains 1 instruction/cycle (count stays at 1, one request in flight).
- Redirect in cycle R: target is issued in R, `out_valid`=0 in R and R+1, and `out_valid`=1 in R+2 with `out_pc`=`branch_target`. The redirect costs 2 bubble cycles.
- Backpressure: the FIFO fills within 2 cycles of `out_ready` falling. When `out_ready` rises, the first pop happens the same cycle and the next issue happens the same cycle.

## Test plan
- Reset release, `out_ready`=1, memory returns `addr>>2`: `out_valid` rises in C2. `out_pc` reads 0,4,8,… and `out_instr` reads 0,1,2,… every cycle with no gaps.
- `out_ready` low for 5 cycles mid-stream: `imem_req` stops after the FIFO plus in-flight slots total 2, with no duplicated or lost PCs. On release, the sequence resumes in order.
- `pc_src`=1 with `branch_target`=0x100 while the FIFO holds 2 entries: `out_valid`=0 for 2 cycles, then `out_pc`=0x100, 0x104, …; the old entries never appear.
- Back-to-back `pc_src` in R (target 0x40) and R+1 (target 0x80): 0x40 is never presented, and the first output is `out_pc`=0x80 at R+3.
- `pc_src` with `branch_target`=2^64−4: outputs are 0xFFFF…FFFC then 0x0, demonstrating the wrap.
- Reset asserted for 1 cycle while the FIFO is full and a request is in flight: `out_valid`=0 for the next 2 cycles, then `out_pc`=RESET_PC.
